// File: rtl/wb_mem_arbiter_pkg.sv
// Shared constants and state encoding for the Wishbone memory-port arbiter.
package wb_mem_arbiter_pkg;

    localparam int RW    = 16;
    localparam int SEL_W = 2;
    localparam int TO_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above ptr, wrapping.
module rr_pick #(
    parameter int NM = 2,
    parameter int GW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = NM - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NM;
            if (req[idx]) begin
                gnt_idx = GW'(idx);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone arbiter with cyc-based bus locking for NM masters.
// Optional stalled-slave timeout error: define ARB_TIMEOUT_EN.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = RW,
    parameter int DW      = RW,
    parameter int TIMEOUT = 255,
    localparam int GW     = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NM-1:0]       m_cyc,
    input  logic [NM-1:0]       m_stb,
    input  logic [NM-1:0]       m_we,
    input  logic [NM*AW-1:0]    m_adr,
    input  logic [NM*DW-1:0]    m_dat_o,
    input  logic [NM*SEL_W-1:0] m_sel,
    output logic [DW-1:0]       m_dat_i,
    output logic [NM-1:0]       m_ack,
    output logic [NM-1:0]       m_err,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [AW-1:0]       s_adr,
    output logic [DW-1:0]       s_dat_o,
    output logic [SEL_W-1:0]    s_sel,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack,
    input  logic                s_err,
    output logic                o_busy,
    output logic [GW-1:0]       o_owner
);

    arb_state_e    state, state_n;
    logic [GW-1:0] owner, owner_n;
    logic [GW-1:0] rr_ptr, rr_ptr_n;
    logic [GW-1:0] pick;
    logic          pick_any;
    logic          busy;
    logic          stb_raw;
    logic          to_hit;

    rr_pick #(.NM(NM), .GW(GW)) u_pick (
        .req     (m_cyc),
        .ptr     (rr_ptr),
        .gnt_idx (pick),
        .any     (pick_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = BUSY;
                    owner_n = pick;
                end
            end
            BUSY: begin
                if (!m_cyc[owner]) begin
                    state_n  = IDLE;
                    rr_ptr_n = (owner == GW'(NM - 1)) ? '0 : owner + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy    = (state == BUSY);
    assign s_cyc   = busy & m_cyc[owner];
    assign stb_raw = s_cyc & m_stb[owner];
    assign s_stb   = stb_raw & ~to_hit;
    assign s_we    = busy & m_we[owner];
    assign s_adr   = m_adr[owner*AW +: AW];
    assign s_dat_o = m_dat_o[owner*DW +: DW];
    assign s_sel   = m_sel[owner*SEL_W +: SEL_W];
    assign m_dat_i = s_dat_i;
    assign o_busy  = busy;
    assign o_owner = owner;

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (busy) begin
            m_ack[owner] = s_ack & s_cyc;
            m_err[owner] = (s_err & s_cyc) | to_hit;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign to_hit = busy && (to_cnt == TO_W'(TIMEOUT));

    // Counts consecutive unanswered strobe cycles; any answer or release restarts it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt <= '0;
        end else if (!busy || to_hit || !(stb_raw & ~s_ack & ~s_err)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    logic unused_to;

    assign to_hit    = 1'b0;
    assign unused_to = ^TO_W'(TIMEOUT);
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_wb_mem_arbiter;

    localparam int NM = 2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 255;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [NM-1:0]   m_cyc, m_stb, m_we;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat_o;
    logic [NM*2-1:0] m_sel;
    logic [DW-1:0]   m_dat_i;
    logic [NM-1:0]   m_ack, m_err;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o;
    logic [1:0]      s_sel;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack, s_err;
    logic            o_busy;
    logic [0:0]      o_owner;

    int total = 0;
    int bad   = 0;

    // reference model state
    int mdl_busy = 0;
    int mdl_own  = 0;
    int mdl_ptr  = 0;
    int mdl_cnt  = 0;

    int n_ack0 = 0;
    int n_ack1 = 0;
    int n_err  = 0;
    int rem [NM];

    wb_mem_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_o (m_dat_o),
        .m_sel   (m_sel),
        .m_dat_i (m_dat_i),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat_o (s_dat_o),
        .s_sel   (s_sel),
        .s_dat_i (s_dat_i),
        .s_ack   (s_ack),
        .s_err   (s_err),
        .o_busy  (o_busy),
        .o_owner (o_owner)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model by one edge.
    task automatic step();
        logic       e_cyc, e_raw, e_stb, e_we, to;
        logic [1:0] e_ack, e_err;
        int         pick;
        bit         found;
        @(negedge i_clk);
        to = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to = (mdl_busy != 0) && (mdl_cnt == TO);
`endif
        e_cyc = 1'b0;
        e_raw = 1'b0;
        e_we  = 1'b0;
        e_ack = '0;
        e_err = '0;
        if (mdl_busy != 0) begin
            e_cyc = m_cyc[mdl_own];
            e_raw = e_cyc & m_stb[mdl_own];
            e_we  = m_we[mdl_own];
            e_ack[mdl_own] = s_ack & e_cyc;
            e_err[mdl_own] = (s_err & e_cyc) | to;
        end
        e_stb = e_raw & ~to;
        check("o_busy", 32'(o_busy), 32'(mdl_busy));
        check("o_owner", 32'(o_owner), 32'(mdl_own));
        check("s_cyc", 32'(s_cyc), 32'(e_cyc));
        check("s_stb", 32'(s_stb), 32'(e_stb));
        check("s_we", 32'(s_we), 32'(e_we));
        check("m_ack", 32'(m_ack), 32'(e_ack));
        check("m_err", 32'(m_err), 32'(e_err));
        check("m_dat_i", 32'(m_dat_i), 32'(s_dat_i));
        if (mdl_busy != 0) begin
            check("s_adr", 32'(s_adr), 32'(m_adr[mdl_own*AW +: AW]));
            check("s_dat_o", 32'(s_dat_o), 32'(m_dat_o[mdl_own*DW +: DW]));
            check("s_sel", 32'(s_sel), 32'(m_sel[mdl_own*2 +: 2]));
        end
        n_ack0 += int'(m_ack[0]);
        n_ack1 += int'(m_ack[1]);
        n_err  += int'(m_err[mdl_own]);

        if (i_rst) begin
            mdl_busy = 0;
            mdl_own  = 0;
            mdl_ptr  = 0;
            mdl_cnt  = 0;
        end else if (mdl_busy == 0) begin
            found = 1'b0;
            pick  = 0;
            for (int k = 0; k < NM; k++) begin
                if (!found && m_cyc[(mdl_ptr + k) % NM]) begin
                    found = 1'b1;
                    pick  = (mdl_ptr + k) % NM;
                end
            end
            if (found) begin
                mdl_busy = 1;
                mdl_own  = pick;
            end
            mdl_cnt = 0;
        end else if (!m_cyc[mdl_own]) begin
            mdl_busy = 0;
            mdl_ptr  = (mdl_own + 1) % NM;
            mdl_cnt  = 0;
        end else if (to || !(e_raw && !s_ack && !s_err)) begin
            mdl_cnt = 0;
        end else begin
            mdl_cnt++;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        s_ack = 1'b0;
        s_err = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst   = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_adr   = {16'h2222, 16'h1111};
        m_dat_o = {16'hbbbb, 16'haaaa};
        m_sel   = 4'b1011;
        s_dat_i = 16'h5a5a;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        @(posedge i_clk);
        #1;
        step();
        check("rst_busy", 32'(o_busy), 32'd0);
        do_reset();

        // single master 8-beat read, slave acks every cycle
        n_ack0 = 0;
        n_ack1 = 0;
        m_cyc  = 2'b01;
        m_stb  = 2'b01;
        s_ack  = 1'b1;
        step();
        repeat (8) step();
        m_cyc = '0;
        m_stb = '0;
        step();
        s_ack = 1'b0;
        step();
        check("burst_ack0", 32'(n_ack0), 32'd8);
        check("burst_ack1", 32'(n_ack1), 32'd0);

        // simultaneous requests from reset: 0, then 1, then 0 again
        do_reset();
        m_cyc = 2'b11;
        m_stb = 2'b11;
        s_ack = 1'b1;
        step();
        check("rr_first", 32'(o_owner), 32'd0);
        repeat (3) step();
        m_cyc = 2'b10;
        step();
        step();
        check("rr_second", 32'(o_owner), 32'd1);
        repeat (2) step();
        m_cyc = 2'b01;
        step();
        m_cyc = 2'b11;
        step();
        step();
        check("rr_third", 32'(o_owner), 32'd0);
        idle_inputs();
        step();
        step();

        // lock: master 1 stalls its strobe while master 0 waits
        do_reset();
        m_cyc = 2'b10;
        m_stb = 2'b10;
        s_ack = 1'b1;
        repeat (3) step();
        m_stb = 2'b00;
        m_cyc = 2'b11;
        repeat (5) step();
        check("lock_owner", 32'(o_owner), 32'd1);
        m_cyc = 2'b01;
        step();
        step();
        step();
        check("lock_next", 32'(o_owner), 32'd0);
        idle_inputs();
        step();

        // slave error on beat 3 keeps ownership
        do_reset();
        n_err = 0;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        s_ack = 1'b1;
        step();
        for (int b = 0; b < 6; b++) begin
            s_err = (b == 2);
            s_ack = (b != 2);
            step();
        end
        check("err_count", 32'(n_err), 32'd1);
        check("err_hold", 32'(o_busy), 32'd1);
        idle_inputs();
        step();

        // reset in the middle of a burst
        do_reset();
        m_cyc = 2'b10;
        m_stb = 2'b10;
        s_ack = 1'b1;
        repeat (4) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        m_cyc = 2'b00;
        n_ack1 = 0;
        step();
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_ack", 32'(n_ack1), 32'd0);
        idle_inputs();
        step();

`ifdef ARB_TIMEOUT_EN
        // silent slave: synthesized error after TIMEOUT cycles of strobe
        do_reset();
        n_err = 0;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        repeat (300) step();
        check("to_err", 32'(n_err), 32'd1);
        idle_inputs();
        step();
`endif

        // random traffic
        for (int k = 0; k < NM; k++) rem[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            i_rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < NM; k++) begin
                if (i_rst) rem[k] = 0;
                else if (rem[k] == 0 && $urandom_range(0, 3) == 0)
                    rem[k] = $urandom_range(1, 12);
                m_cyc[k] = (rem[k] > 0);
                m_stb[k] = ($urandom_range(0, 9) < 7);
                m_we[k]  = 1'($urandom);
            end
            m_adr   = 32'($urandom);
            m_dat_o = 32'($urandom);
            m_sel   = 4'($urandom);
            s_dat_i = 16'($urandom);
            s_ack   = 1'($urandom);
            s_err   = ($urandom_range(0, 7) == 0);
            step();
            for (int k = 0; k < NM; k++)
                if (rem[k] > 0) rem[k]--;
        end
        i_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
